apb_req_arbiter: RTL and testbench

//  Shares the single APB write master among NREQ requesters, with round-robin arbitration.

---
 rtl/apb_req_arbiter_pkg.sv | 28 ++
 rtl/apb_req_arbiter_rr_arbiter.sv | 32 +++
 rtl/apb_req_arbiter.sv | 127 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_req_arbiter_pkg.sv
// Shared definitions for the APB write-request arbiter: state encodings,
// default payload widths and the grant-index width helper.
package apb_req_arbiter_pkg;

    localparam int AW_DEFAULT   = 32;
    localparam int DW_DEFAULT   = 32;
    localparam int SELW_DEFAULT = 2;

    typedef enum logic [2:0] {
        ST_ARB    = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DONE   = 3'd3,
        ST_REJECT = 3'd4
    } arb_state_t;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2
    } mst_state_t;

    // A single requester still needs one bit to name it.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational rotating-priority pick: the first set request strictly after
// rr_ptr, wrapping around, wins.
module rr_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit
    // is the last one written and therefore the one that sticks.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB write master among NREQ requesters: round-robin pick, payload
// latch, one-cycle issue pulse, completion detect and done/err acknowledge.
module apb_req_arbiter
    import apb_req_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT,
    parameter int SELW = SELW_DEFAULT,
    localparam int IW  = id_width(NREQ)
) (
    input  logic                 pclk,
    input  logic                 prst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    input  logic [NREQ*SELW-1:0] req_sel,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic                 m_valid,
    output logic                 m_write,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    output logic [SELW-1:0]      m_sel,
    input  logic                 penable,
    input  logic                 pready,
    output logic [IW-1:0]        grant_id,
    output logic                 busy
);

    arb_state_t      state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_wdata;
    logic [SELW-1:0] win_sel;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_sel   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IW'(k)) begin
                win_addr  = req_addr[k*AW +: AW];
                win_wdata = req_wdata[k*DW +: DW];
                win_sel   = req_sel[k*SELW +: SELW];
            end
        end
    end

    // The master only ever writes.
    assign m_write = 1'b1;

    // The m_* payload is only reloaded in ARB, so it stays stable from the
    // issue pulse until the arbiter returns to ARB after the transfer.
    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            state    <= ST_ARB;
            rr_ptr   <= IW'(NREQ - 1);
            grant_id <= '0;
            m_valid  <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_sel    <= '0;
            busy     <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (any_req) begin
                        grant_id <= winner;
                        m_addr   <= win_addr;
                        m_wdata  <= win_wdata;
                        m_sel    <= win_sel;
                        busy     <= 1'b1;
                        if (win_sel == '0) begin
                            req_err[winner] <= 1'b1;
                            state           <= ST_REJECT;
                        end else begin
                            m_valid <= 1'b1;
                            state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    m_valid <= 1'b0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (penable && pready) begin
                        req_done[grant_id] <= 1'b1;
                        state              <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_done <= '0;
                    rr_ptr   <= grant_id;
                    busy     <= 1'b0;
                    state    <= ST_ARB;
                end
                ST_REJECT: begin
                    req_err <= '0;
                    rr_ptr  <= grant_id;
                    busy    <= 1'b0;
                    state   <= ST_ARB;
                end
                default: begin
                    m_valid  <= 1'b0;
                    req_done <= '0;
                    req_err  <= '0;
                    busy     <= 1'b0;
                    state    <= ST_ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter with a behavioural APB master, a slave
// with programmable pready delay, and a rotation model of the grant order.
module tb_apb_req_arbiter;
    import apb_req_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SELW = 2;
    localparam int IW   = 2;

    logic                 pclk;
    logic                 prst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ-1:0]      req_done;
    logic [NREQ-1:0]      req_err;
    logic                 m_valid;
    logic                 m_write;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic [SELW-1:0]      m_sel;
    logic                 dut_penable;
    logic                 pready;
    logic [IW-1:0]        grant_id;
    logic                 busy;
    logic                 spur_pen;

    mst_state_t    mst_st       = M_IDLE;
    int            acc_cnt      = 0;
    int            pready_delay = 0;
    int            cyc          = 0;
    logic [AW-1:0] slv_addr     = '0;
    logic [DW-1:0] slv_data     = '0;
    logic [SELW-1:0] slv_sel    = '0;

    typedef struct {
        int              id;
        bit              is_err;
        int              cyc;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [SELW-1:0] sel;
    } ev_t;

    ev_t exp_q[$];
    ev_t iss_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rr_model = NREQ - 1;

    logic [AW-1:0]   addr_v [NREQ];
    logic [DW-1:0]   data_v [NREQ];
    logic [SELW-1:0] sel_v  [NREQ];

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SELW(SELW)) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_done  (req_done),
        .req_err   (req_err),
        .m_valid   (m_valid),
        .m_write   (m_write),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_sel     (m_sel),
        .penable   (dut_penable),
        .pready    (pready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Master sees the issue pulse, then runs SETUP and ACCESS; the slave adds
    // pready_delay wait states and captures the write on completion. Neither
    // has a reset, like the real parts.
    assign dut_penable = (mst_st == M_ACCESS) || spur_pen;
    assign pready      = (acc_cnt >= pready_delay);

    always @(posedge pclk) begin
        cyc <= cyc + 1;
        case (mst_st)
            M_IDLE:   if (m_valid) mst_st <= M_SETUP;
            M_SETUP:  mst_st <= M_ACCESS;
            M_ACCESS: begin
                if (pready) begin
                    mst_st   <= M_IDLE;
                    acc_cnt  <= 0;
                    slv_addr <= m_addr;
                    slv_data <= m_wdata;
                    slv_sel  <= m_sel;
                end else begin
                    acc_cnt <= acc_cnt + 1;
                end
            end
            default:  mst_st <= M_IDLE;
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Monitor: every issue pulse and every done/err pulse must match the
    // oldest outstanding expectation.
    always @(negedge pclk) begin
        ev_t e;
        if (prst) begin
            if (m_valid) begin
                if (iss_q.size() == 0) begin
                    checkOutput("unexpected_m_valid", 64'(m_valid), 64'd0);
                end else begin
                    e = iss_q.pop_front();
                    checkOutput("issue_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("m_addr", 64'(m_addr), 64'(e.addr));
                    checkOutput("m_wdata", 64'(m_wdata), 64'(e.data));
                    checkOutput("m_sel", 64'(m_sel), 64'(e.sel));
                    checkOutput("m_write", 64'(m_write), 64'd1);
                    checkOutput("busy_at_issue", 64'(busy), 64'd1);
                end
            end
            if ((req_done | req_err) != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", 64'({req_done, req_err}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("req_done", 64'(req_done), e.is_err ? 64'd0 : 64'(onehot(e.id)));
                    checkOutput("req_err", 64'(req_err), e.is_err ? 64'(onehot(e.id)) : 64'd0);
                    checkOutput("pulse_cycle", 64'(cyc), 64'(e.cyc));
                    checkOutput("grant_id", 64'(grant_id), 64'(e.id));
                    if (!e.is_err) begin
                        checkOutput("slave_addr", 64'(slv_addr), 64'(e.addr));
                        checkOutput("slave_data", 64'(slv_data), 64'(e.data));
                        checkOutput("slave_sel", 64'(slv_sel), 64'(e.sel));
                    end
                end
            end
        end
    end

    task automatic randPayload(input bit legal);
        for (int k = 0; k < NREQ; k++) begin
            addr_v[k] = $urandom;
            data_v[k] = $urandom;
            if (!legal && $urandom_range(0, 4) == 0)
                sel_v[k] = '0;
            else
                sel_v[k] = SELW'($urandom_range(1, 3));
        end
    endtask

    task automatic drivePayload();
        for (int k = 0; k < NREQ; k++) begin
            req_addr[k*AW +: AW]      = addr_v[k];
            req_wdata[k*DW +: DW]     = data_v[k];
            req_sel[k*SELW +: SELW]   = sel_v[k];
        end
    endtask

    // One round: the requesters in mask raise together and each drops on its
    // own done/err pulse. The reference serves them in circular order after
    // the last winner: a transfer occupies 5+d cycles (done in the 5th), a
    // reject occupies 2 (err in the 2nd).
    task automatic applyStimulus(input logic [NREQ-1:0] mask, input int d,
                                 input int drop_id, input bit spur_issue);
        int              p0;
        int              t;
        int              i;
        int              n;
        bit              spur_done;
        logic [NREQ-1:0] pending;
        ev_t             e;
        pready_delay = d;
        @(negedge pclk);
        drivePayload();
        req_valid = mask;
        t  = cyc;
        p0 = rr_model;
        for (int k = 1; k <= NREQ; k++) begin
            i = (p0 + k) % NREQ;
            if (mask[i]) begin
                e.id   = i;
                e.addr = addr_v[i];
                e.data = data_v[i];
                e.sel  = sel_v[i];
                if (sel_v[i] == '0) begin
                    e.is_err = 1'b1;
                    e.cyc    = t + 1;
                    exp_q.push_back(e);
                    t = t + 2;
                end else begin
                    e.is_err = 1'b0;
                    e.cyc    = t + 1;
                    iss_q.push_back(e);
                    e.cyc    = t + 4 + d;
                    exp_q.push_back(e);
                    t = t + 5 + d;
                end
                rr_model = i;
            end
        end
        pending   = mask;
        spur_done = 1'b0;
        for (n = 0; n < 400 && pending != '0; n++) begin
            @(negedge pclk);
            spur_pen = 1'b0;
            if (spur_issue && !spur_done && m_valid) begin
                spur_pen  = 1'b1;
                spur_done = 1'b1;
            end
            pending   = pending & ~(req_done | req_err);
            req_valid = req_valid & ~(req_done | req_err);
            if (drop_id >= 0 && mst_st == M_ACCESS)
                req_valid[drop_id] = 1'b0;
        end
        spur_pen = 1'b0;
        if (pending != '0) begin
            checkOutput("round_timeout", 64'(pending), 64'd0);
            req_valid = '0;
            exp_q.delete();
            iss_q.delete();
        end
    endtask

    initial begin
        int  n;
        ev_t e;
        prst      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_sel   = '0;
        spur_pen  = 1'b0;
        repeat (3) @(negedge pclk);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_write", 64'(m_write), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_grant_id", 64'(grant_id), 64'd0);
        checkOutput("rst_done_err", 64'({req_done, req_err}), 64'd0);
        checkOutput("rst_m_addr", 64'(m_addr), 64'd0);
        prst = 1'b1;

        $display("[TB] contention: all four from reset, then 1 and 3");
        randPayload(1'b1);
        applyStimulus(4'b1111, 0, -1, 1'b0);
        randPayload(1'b1);
        applyStimulus(4'b1010, 0, -1, 1'b0);

        $display("[TB] single request latency");
        randPayload(1'b1);
        addr_v[0] = 32'h10;
        data_v[0] = 32'hCAFE;
        sel_v[0]  = 2'b01;
        applyStimulus(4'b0001, 0, -1, 1'b0);

        $display("[TB] five pready wait states");
        randPayload(1'b1);
        applyStimulus(4'b0001, 5, -1, 1'b0);

        $display("[TB] illegal select, then rotation resumes after 2");
        randPayload(1'b1);
        sel_v[2] = '0;
        applyStimulus(4'b0100, 0, -1, 1'b0);
        randPayload(1'b1);
        applyStimulus(4'b1111, 1, -1, 1'b0);

        $display("[TB] stray completion handshakes outside WAIT");
        @(negedge pclk);
        spur_pen = 1'b1;
        @(negedge pclk);
        spur_pen = 1'b0;
        repeat (2) @(negedge pclk);
        checkOutput("idle_spur_busy", 64'(busy), 64'd0);
        randPayload(1'b1);
        applyStimulus(4'b0001, 0, -1, 1'b1);

        $display("[TB] request dropped mid-transfer");
        randPayload(1'b1);
        applyStimulus(4'b0010, 1, 1, 1'b0);

        $display("[TB] reset while the master is in ACCESS");
        randPayload(1'b1);
        pready_delay = 5;
        @(negedge pclk);
        drivePayload();
        req_valid = 4'b0001;
        e.id     = 0;
        e.is_err = 1'b0;
        e.cyc    = cyc + 1;
        e.addr   = addr_v[0];
        e.data   = data_v[0];
        e.sel    = sel_v[0];
        iss_q.push_back(e);
        for (n = 0; n < 50 && mst_st != M_ACCESS; n++) @(negedge pclk);
        checkOutput("t5_reached_access", 64'(mst_st == M_ACCESS), 64'd1);
        #2;
        prst      = 1'b0;
        req_valid = '0;
        exp_q.delete();
        iss_q.delete();
        rr_model  = NREQ - 1;
        #1;
        checkOutput("t5_m_valid", 64'(m_valid), 64'd0);
        checkOutput("t5_m_write", 64'(m_write), 64'd1);
        checkOutput("t5_busy", 64'(busy), 64'd0);
        checkOutput("t5_grant_id", 64'(grant_id), 64'd0);
        checkOutput("t5_done_err", 64'({req_done, req_err}), 64'd0);
        checkOutput("t5_payload", 64'({m_addr, m_sel}), 64'd0);
        checkOutput("t5_m_wdata", 64'(m_wdata), 64'd0);
        repeat (2) @(negedge pclk);
        prst = 1'b1;
        for (n = 0; n < 50 && mst_st != M_IDLE; n++) @(negedge pclk);
        checkOutput("t5_master_idle", 64'(mst_st == M_IDLE), 64'd1);
        checkOutput("t5_ignored_busy", 64'(busy), 64'd0);
        randPayload(1'b1);
        applyStimulus(4'b0001, 0, -1, 1'b0);

        $display("[TB] random rounds");
        for (int r = 0; r < 30; r++) begin
            randPayload(1'b0);
            applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)),
                          int'($urandom_range(0, 3)), -1, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        repeat (3) @(negedge pclk);
        checkOutput("exp_q_drained", 64'(exp_q.size()), 64'd0);
        checkOutput("iss_q_drained", 64'(iss_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
